// File: rtl/axi4l_ipif_master_if.sv
// AXI4-Lite bus bundle between the IPIF-style master and the interconnect.
// The master modport drives AW/W/AR and the B/R ready signals; the slave modport mirrors it.
interface axi4l_ipif_master_if #(
    parameter int C_DATA_WIDTH = 32
);
    logic [31:0]               awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [C_DATA_WIDTH-1:0]   wdata;
    logic [C_DATA_WIDTH/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [31:0]               araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [C_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_ipif_master.sv
// AXI4-Lite master: converts single-cycle wr_req/rd_req register requests into AXI4-Lite
// transactions. Independent write and read FSMs; every output is driven from a flop.
module axi4l_ipif_master #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [C_ADDR_WIDTH-3:0]   wr_addr,
    input  logic                      wr_req,
    input  logic [C_DATA_WIDTH/8-1:0] wr_be,
    input  logic [C_DATA_WIDTH-1:0]   wr_data,
    output logic                      wr_ack,
    output logic                      wr_err,
    output logic                      wr_busy,

    input  logic [C_ADDR_WIDTH-3:0]   rd_addr,
    input  logic                      rd_req,
    output logic [C_DATA_WIDTH-1:0]   rd_data,
    output logic                      rd_ack,
    output logic                      rd_err,
    output logic                      rd_busy,

    axi4l_ipif_master_if.master       m_axi
);

    localparam int STRB_W = C_DATA_WIDTH / 8;

    generate
        if (!(C_DATA_WIDTH == 32 || C_DATA_WIDTH == 64)) begin : g_bad_data_width
            $error("axi4l_ipif_master: C_DATA_WIDTH must be 32 or 64");
        end
        if (C_ADDR_WIDTH < 3 || C_ADDR_WIDTH > 32) begin : g_bad_addr_width
            $error("axi4l_ipif_master: C_ADDR_WIDTH must be in 3..32");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_RESP
    } wr_state_t;

    wr_state_t           wr_state_reg;
    logic [31:0]         awaddr_reg;
    logic                awvalid_reg;
    logic [C_DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_W-1:0]   wstrb_reg;
    logic                wvalid_reg;
    logic                bready_reg;
    logic                wr_ack_reg;
    logic                wr_err_reg;
    logic                wr_busy_reg;

    // A channel counts as done once its valid has dropped or is handshaking right now.
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_reg || m_axi.awready;
    assign w_done  = !wvalid_reg  || m_axi.wready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_reg <= W_IDLE;
            awaddr_reg   <= '0;
            awvalid_reg  <= 1'b0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            wvalid_reg   <= 1'b0;
            bready_reg   <= 1'b0;
            wr_ack_reg   <= 1'b0;
            wr_err_reg   <= 1'b0;
            wr_busy_reg  <= 1'b0;
        end else begin
            wr_ack_reg <= 1'b0;
            case (wr_state_reg)
                W_IDLE: begin
                    if (wr_req) begin
                        awaddr_reg   <= 32'({wr_addr, 2'b00});
                        wdata_reg    <= wr_data;
                        wstrb_reg    <= wr_be;
                        awvalid_reg  <= 1'b1;
                        wvalid_reg   <= 1'b1;
                        wr_busy_reg  <= 1'b1;
                        wr_state_reg <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (awvalid_reg && m_axi.awready) begin
                        awvalid_reg <= 1'b0;
                    end
                    if (wvalid_reg && m_axi.wready) begin
                        wvalid_reg <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_reg   <= 1'b1;
                        wr_state_reg <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (m_axi.bvalid && bready_reg) begin
                        bready_reg   <= 1'b0;
                        wr_ack_reg   <= 1'b1;
                        wr_err_reg   <= m_axi.bresp[1];
                        wr_busy_reg  <= 1'b0;
                        wr_state_reg <= W_IDLE;
                    end
                end
                default: begin
                    wr_state_reg <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_t;

    rd_state_t           rd_state_reg;
    logic [31:0]         araddr_reg;
    logic                arvalid_reg;
    logic                rready_reg;
    logic [C_DATA_WIDTH-1:0] rd_data_reg;
    logic                rd_ack_reg;
    logic                rd_err_reg;
    logic                rd_busy_reg;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state_reg <= R_IDLE;
            araddr_reg   <= '0;
            arvalid_reg  <= 1'b0;
            rready_reg   <= 1'b0;
            rd_data_reg  <= '0;
            rd_ack_reg   <= 1'b0;
            rd_err_reg   <= 1'b0;
            rd_busy_reg  <= 1'b0;
        end else begin
            rd_ack_reg <= 1'b0;
            case (rd_state_reg)
                R_IDLE: begin
                    if (rd_req) begin
                        araddr_reg   <= 32'({rd_addr, 2'b00});
                        arvalid_reg  <= 1'b1;
                        rd_busy_reg  <= 1'b1;
                        rd_state_reg <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (arvalid_reg && m_axi.arready) begin
                        arvalid_reg  <= 1'b0;
                        rready_reg   <= 1'b1;
                        rd_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    // Data is returned even on an error response.
                    if (m_axi.rvalid && rready_reg) begin
                        rready_reg   <= 1'b0;
                        rd_data_reg  <= m_axi.rdata;
                        rd_err_reg   <= m_axi.rresp[1];
                        rd_ack_reg   <= 1'b1;
                        rd_busy_reg  <= 1'b0;
                        rd_state_reg <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    // EXOKAY and OKAY both map to success, so only the upper response bit matters.
    logic unused_resp_lsb;
    assign unused_resp_lsb = m_axi.bresp[0] ^ m_axi.rresp[0];

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign m_axi.awaddr  = awaddr_reg;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_reg;
    assign m_axi.wdata   = wdata_reg;
    assign m_axi.wstrb   = wstrb_reg;
    assign m_axi.wvalid  = wvalid_reg;
    assign m_axi.bready  = bready_reg;
    assign m_axi.araddr  = araddr_reg;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_reg;
    assign m_axi.rready  = rready_reg;

    assign wr_ack  = wr_ack_reg;
    assign wr_err  = wr_err_reg;
    assign wr_busy = wr_busy_reg;
    assign rd_data = rd_data_reg;
    assign rd_ack  = rd_ack_reg;
    assign rd_err  = rd_err_reg;
    assign rd_busy = rd_busy_reg;

endmodule

// File: tb/tb_axi4l_ipif_master.sv
// Directed self-checking bench for axi4l_ipif_master; the bench plays the AXI4-Lite slave.
`timescale 1ns/1ps
module tb_axi4l_ipif_master;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [9:0]  wr_addr;
    logic        wr_req;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_ack, wr_err, wr_busy;
    logic [9:0]  rd_addr;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_ack, rd_err, rd_busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int aw_hs_count  = 0;

    axi4l_ipif_master_if #(.C_DATA_WIDTH(32)) m_axi();

    axi4l_ipif_master #(
        .C_ADDR_WIDTH(12),
        .C_DATA_WIDTH(32)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_addr (wr_addr),
        .wr_req  (wr_req),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .wr_err  (wr_err),
        .wr_busy (wr_busy),
        .rd_addr (rd_addr),
        .rd_req  (rd_req),
        .rd_data (rd_data),
        .rd_ack  (rd_ack),
        .rd_err  (rd_err),
        .rd_busy (rd_busy),
        .m_axi   (m_axi)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (m_axi.awvalid && m_axi.awready) aw_hs_count <= aw_hs_count + 1;
    end

    logic [148:0] all_outs;
    assign all_outs = {wr_ack, wr_err, wr_busy, rd_data, rd_ack, rd_err, rd_busy,
                       m_axi.awaddr, m_axi.awprot, m_axi.awvalid, m_axi.wdata, m_axi.wstrb,
                       m_axi.wvalid, m_axi.bready, m_axi.araddr, m_axi.arprot,
                       m_axi.arvalid, m_axi.rready};

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (all_outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 0", all_outs);
        end
        wr_req = 1'b1; rd_req = 1'b1; wr_addr = 10'h3; rd_addr = 10'h4;
        tick();
        tests_run++;
        if (all_outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_ignores_req: got %h required 0", all_outs);
        end
        wr_req = 1'b0; rd_req = 1'b0; aresetn = 1'b1;
        tick();
        tests_run++;
        if ({wr_busy, rd_busy, m_axi.awvalid, m_axi.arvalid} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got %b required 0000",
                     {wr_busy, rd_busy, m_axi.awvalid, m_axi.arvalid});
        end
        $display("[TB] reset sequence done");
    endtask

    task automatic test_write_zero_wait();
        m_axi.awready = 1'b1; m_axi.wready = 1'b1; m_axi.bvalid = 1'b0;
        wr_addr = 10'h005; wr_data = 32'hDEADBEEF; wr_be = 4'hF; wr_req = 1'b1;
        tick(); // edge 0
        wr_req = 1'b0;
        tests_run++;
        if ({m_axi.awvalid, m_axi.wvalid, m_axi.awaddr, m_axi.wdata, m_axi.wstrb}
            !== {1'b1, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF}) begin
            tests_failed++;
            $display("FAIL wr0_payload: got av=%b wv=%b a=%h d=%h s=%h required 1 1 14 deadbeef f",
                     m_axi.awvalid, m_axi.wvalid, m_axi.awaddr, m_axi.wdata, m_axi.wstrb);
        end
        tick(); // edge 1: both handshakes
        tests_run++;
        if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, wr_ack} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL wr0_after_hs: got %b required 0010",
                     {m_axi.awvalid, m_axi.wvalid, m_axi.bready, wr_ack});
        end
        m_axi.bvalid = 1'b1; m_axi.bresp = 2'b00;
        tick(); // edge 2: B handshake
        m_axi.bvalid = 1'b0;
        tests_run++;
        if ({wr_ack, wr_err, m_axi.bready, wr_busy} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL wr0_ack: got %b required 1000", {wr_ack, wr_err, m_axi.bready, wr_busy});
        end
        tick();
        tests_run++;
        if (wr_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr0_ack_width: got %b required 0", wr_ack);
        end
        $display("[TB] write addr=005 data=deadbeef be=f bresp=0");
    endtask

    task automatic test_split_write();
        m_axi.awready = 1'b0; m_axi.wready = 1'b1; m_axi.bvalid = 1'b0;
        wr_addr = 10'h02A; wr_data = 32'hCAFEF00D; wr_be = 4'h3; wr_req = 1'b1;
        tick(); // edge 0
        wr_req = 1'b0;
        tests_run++;
        if ({m_axi.awvalid, m_axi.wvalid} !== 2'b11) begin
            tests_failed++;
            $display("FAIL split_issue: got %b required 11", {m_axi.awvalid, m_axi.wvalid});
        end
        tick(); // edge 1: W handshake only
        tests_run++;
        if ({m_axi.wvalid, m_axi.awvalid, m_axi.bready, m_axi.awaddr} !== {3'b010, 32'hA8}) begin
            tests_failed++;
            $display("FAIL split_w_drop: got wv=%b av=%b br=%b a=%h required 0 1 0 a8",
                     m_axi.wvalid, m_axi.awvalid, m_axi.bready, m_axi.awaddr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({m_axi.awvalid, m_axi.bready, m_axi.awaddr} !== {2'b10, 32'hA8}) begin
                tests_failed++;
                $display("FAIL split_aw_hold%0d: got av=%b br=%b a=%h required 1 0 a8",
                         i, m_axi.awvalid, m_axi.bready, m_axi.awaddr);
            end
        end
        m_axi.awready = 1'b1;
        tick(); // AW handshake
        m_axi.awready = 1'b0;
        tests_run++;
        if ({m_axi.awvalid, m_axi.bready, wr_ack} !== 3'b010) begin
            tests_failed++;
            $display("FAIL split_bready: got %b required 010", {m_axi.awvalid, m_axi.bready, wr_ack});
        end
        m_axi.bvalid = 1'b1; m_axi.bresp = 2'b01; // EXOKAY counts as success
        tick();
        m_axi.bvalid = 1'b0;
        tests_run++;
        if ({wr_ack, wr_err, m_axi.bready} !== 3'b100) begin
            tests_failed++;
            $display("FAIL split_ack: got %b required 100", {wr_ack, wr_err, m_axi.bready});
        end
        $display("[TB] write addr=02a data=cafef00d be=3 split handshake bresp=1");
    endtask

    task automatic test_read_error();
        m_axi.arready = 1'b0; m_axi.rvalid = 1'b0;
        rd_addr = 10'h3FF; rd_req = 1'b1;
        tick(); // edge 0
        rd_req = 1'b0;
        tests_run++;
        if ({m_axi.arvalid, m_axi.rready, rd_busy, m_axi.araddr} !== {3'b101, 32'hFFC}) begin
            tests_failed++;
            $display("FAIL rd_issue: got av=%b rr=%b busy=%b a=%h required 1 0 1 ffc",
                     m_axi.arvalid, m_axi.rready, rd_busy, m_axi.araddr);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if ({m_axi.arvalid, m_axi.rready} !== 2'b10) begin
                tests_failed++;
                $display("FAIL rd_ar_wait%0d: got %b required 10", i, {m_axi.arvalid, m_axi.rready});
            end
        end
        m_axi.arready = 1'b1;
        tick(); // AR handshake
        m_axi.arready = 1'b0;
        tests_run++;
        if ({m_axi.arvalid, m_axi.rready, rd_ack} !== 3'b010) begin
            tests_failed++;
            $display("FAIL rd_rready: got %b required 010", {m_axi.arvalid, m_axi.rready, rd_ack});
        end
        m_axi.rvalid = 1'b1; m_axi.rdata = 32'h12345678; m_axi.rresp = 2'b10;
        tick();
        m_axi.rvalid = 1'b0; m_axi.rdata = 32'h0;
        tests_run++;
        if ({rd_ack, rd_err, m_axi.rready, rd_busy, rd_data} !== {4'b1100, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL rd_err_ack: got ack=%b err=%b rr=%b busy=%b d=%h required 1 1 0 0 12345678",
                     rd_ack, rd_err, m_axi.rready, rd_busy, rd_data);
        end
        tick();
        tests_run++;
        if ({rd_ack, rd_err, rd_data} !== {2'b01, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL rd_hold: got ack=%b err=%b d=%h required 0 1 12345678",
                     rd_ack, rd_err, rd_data);
        end
        $display("[TB] read addr=3ff data=12345678 rresp=2");
    endtask

    task automatic test_concurrent();
        int d_aw, d_w, d_b, d_ar, d_r;
        int got_wr = 0;
        int got_rd = 0;
        logic [31:0] cap_awaddr, cap_wdata, cap_araddr, cap_rd_data;
        logic [3:0]  cap_wstrb;
        logic        cap_wr_err, cap_rd_err;
        d_aw = $urandom_range(0, 3); d_w = $urandom_range(0, 3); d_b = $urandom_range(0, 3);
        d_ar = $urandom_range(0, 3); d_r = $urandom_range(0, 3);
        m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0;
        m_axi.arready = 1'b0; m_axi.rvalid = 1'b0;
        wr_addr = 10'h011; wr_data = 32'hA5A50F0F; wr_be = 4'hC; wr_req = 1'b1;
        rd_addr = 10'h022; rd_req = 1'b1;
        fork
            begin
                tick();
                wr_req = 1'b0; rd_req = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    if (wr_ack) begin got_wr++; cap_wr_err = wr_err; end
                    if (rd_ack) begin got_rd++; cap_rd_err = rd_err; cap_rd_data = rd_data; end
                    tick();
                end
            end
            begin
                repeat (d_aw) tick();
                m_axi.awready = 1'b1;
                for (int i = 0; i < 30; i++) begin
                    if (m_axi.awvalid) begin cap_awaddr = m_axi.awaddr; tick(); break; end
                    tick();
                end
                m_axi.awready = 1'b0;
            end
            begin
                repeat (d_w) tick();
                m_axi.wready = 1'b1;
                for (int i = 0; i < 30; i++) begin
                    if (m_axi.wvalid) begin
                        cap_wdata = m_axi.wdata; cap_wstrb = m_axi.wstrb; tick(); break;
                    end
                    tick();
                end
                m_axi.wready = 1'b0;
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    if (m_axi.bready) break;
                    tick();
                end
                repeat (d_b) tick();
                m_axi.bvalid = 1'b1; m_axi.bresp = 2'b11;
                tick();
                m_axi.bvalid = 1'b0;
            end
            begin
                repeat (d_ar) tick();
                m_axi.arready = 1'b1;
                for (int i = 0; i < 30; i++) begin
                    if (m_axi.arvalid) begin cap_araddr = m_axi.araddr; tick(); break; end
                    tick();
                end
                m_axi.arready = 1'b0;
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    if (m_axi.rready) break;
                    tick();
                end
                repeat (d_r) tick();
                m_axi.rvalid = 1'b1; m_axi.rdata = 32'h0BADCAFE; m_axi.rresp = 2'b00;
                tick();
                m_axi.rvalid = 1'b0; m_axi.rdata = 32'h0;
            end
        join
        tests_run++;
        if ({got_wr, got_rd} !== {32'd1, 32'd1}) begin
            tests_failed++;
            $display("FAIL conc_ack_count: got wr=%0d rd=%0d required 1 1", got_wr, got_rd);
        end
        tests_run++;
        if ({cap_awaddr, cap_wdata, cap_wstrb, cap_wr_err} !== {32'h44, 32'hA5A50F0F, 4'hC, 1'b1}) begin
            tests_failed++;
            $display("FAIL conc_write: got a=%h d=%h s=%h err=%b required 44 a5a50f0f c 1",
                     cap_awaddr, cap_wdata, cap_wstrb, cap_wr_err);
        end
        tests_run++;
        if ({cap_araddr, cap_rd_data, cap_rd_err} !== {32'h88, 32'h0BADCAFE, 1'b0}) begin
            tests_failed++;
            $display("FAIL conc_read: got a=%h d=%h err=%b required 88 0badcafe 0",
                     cap_araddr, cap_rd_data, cap_rd_err);
        end
        $display("[TB] concurrent write addr=011 and read addr=022 delays aw=%0d w=%0d b=%0d ar=%0d r=%0d",
                 d_aw, d_w, d_b, d_ar, d_r);
    endtask

    task automatic test_back_to_back();
        int aw0;
        aw0 = aw_hs_count;
        m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0;
        wr_addr = 10'h007; wr_data = 32'h11112222; wr_be = 4'hF; wr_req = 1'b1;
        tick(); // edge 0
        wr_addr = 10'h003; wr_data = 32'h33334444; // second request while busy
        tests_run++;
        if ({wr_busy, m_axi.awaddr} !== {1'b1, 32'h1C}) begin
            tests_failed++;
            $display("FAIL b2b_busy: got busy=%b a=%h required 1 1c", wr_busy, m_axi.awaddr);
        end
        tick(); // edge 1: ignored
        wr_req = 1'b0;
        tests_run++;
        if ({m_axi.awaddr, m_axi.wdata} !== {32'h1C, 32'h11112222}) begin
            tests_failed++;
            $display("FAIL b2b_ignored: got a=%h d=%h required 1c 11112222", m_axi.awaddr, m_axi.wdata);
        end
        m_axi.awready = 1'b1; m_axi.wready = 1'b1;
        tick(); // edge 2: handshakes
        m_axi.bvalid = 1'b1; m_axi.bresp = 2'b00;
        tick(); // edge 3: ack
        m_axi.bvalid = 1'b0;
        tests_run++;
        if (wr_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first_ack: got %b required 1", wr_ack);
        end
        wr_addr = 10'h009; wr_data = 32'h55556666; wr_req = 1'b1; // in the ack cycle
        tick(); // edge 4
        wr_req = 1'b0;
        tests_run++;
        if ({m_axi.awvalid, wr_ack, m_axi.awaddr, m_axi.wdata} !== {2'b10, 32'h24, 32'h55556666}) begin
            tests_failed++;
            $display("FAIL b2b_reissue: got av=%b ack=%b a=%h d=%h required 1 0 24 55556666",
                     m_axi.awvalid, wr_ack, m_axi.awaddr, m_axi.wdata);
        end
        tick(); // edge 5: handshakes
        m_axi.bvalid = 1'b1;
        tick(); // edge 6: ack
        m_axi.bvalid = 1'b0; m_axi.awready = 1'b0; m_axi.wready = 1'b0;
        tests_run++;
        if (wr_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second_ack: got %b required 1", wr_ack);
        end
        tick();
        tests_run++;
        if (aw_hs_count - aw0 !== 2) begin
            tests_failed++;
            $display("FAIL b2b_aw_count: got %0d required 2", aw_hs_count - aw0);
        end
        $display("[TB] back-to-back writes addr=007 then addr=009 (addr=003 ignored)");
    endtask

    task automatic test_reset_mid();
        m_axi.awready = 1'b1; m_axi.wready = 1'b1; m_axi.arready = 1'b1;
        m_axi.bvalid = 1'b0; m_axi.rvalid = 1'b0;
        wr_addr = 10'h055; wr_data = 32'h01020304; wr_be = 4'h5; wr_req = 1'b1;
        rd_addr = 10'h066; rd_req = 1'b1;
        tick(); // edge 0
        wr_req = 1'b0; rd_req = 1'b0;
        tick(); // edge 1: now in W_RESP / R_DATA
        tests_run++;
        if ({m_axi.bready, m_axi.rready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rstmid_resp_state: got %b required 11", {m_axi.bready, m_axi.rready});
        end
        aresetn = 1'b0;
        m_axi.bvalid = 1'b1; m_axi.bresp = 2'b10;
        m_axi.rvalid = 1'b1; m_axi.rdata = 32'h99999999; m_axi.rresp = 2'b10;
        tick();
        tests_run++;
        if (all_outs !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got %h required 0", all_outs);
        end
        aresetn = 1'b1; m_axi.bvalid = 1'b0; m_axi.rvalid = 1'b0;
        tick();
        tests_run++;
        if (all_outs !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_no_ack: got %h required 0", all_outs);
        end
        wr_addr = 10'h0F0; wr_data = 32'h76543210; wr_be = 4'hF; wr_req = 1'b1;
        rd_addr = 10'h0F1; rd_req = 1'b1;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        tests_run++;
        if ({m_axi.awaddr, m_axi.araddr} !== {32'h3C0, 32'h3C4}) begin
            tests_failed++;
            $display("FAIL rstmid_reissue: got aw=%h ar=%h required 3c0 3c4", m_axi.awaddr, m_axi.araddr);
        end
        tick();
        m_axi.bvalid = 1'b1; m_axi.bresp = 2'b00;
        m_axi.rvalid = 1'b1; m_axi.rdata = 32'hFEEDFACE; m_axi.rresp = 2'b01;
        tick();
        m_axi.bvalid = 1'b0; m_axi.rvalid = 1'b0;
        tests_run++;
        if ({wr_ack, wr_err, rd_ack, rd_err, rd_data} !== {4'b1010, 32'hFEEDFACE}) begin
            tests_failed++;
            $display("FAIL rstmid_recover: got wa=%b we=%b ra=%b re=%b d=%h required 1 0 1 0 feedface",
                     wr_ack, wr_err, rd_ack, rd_err, rd_data);
        end
        $display("[TB] reset mid-transaction, then write addr=0f0 and read addr=0f1");
    endtask

    initial begin
        aresetn = 1'b0;
        wr_addr = '0; wr_req = 1'b0; wr_be = '0; wr_data = '0;
        rd_addr = '0; rd_req = 1'b0;
        m_axi.awready = 1'b0; m_axi.wready = 1'b0;
        m_axi.bresp = 2'b00; m_axi.bvalid = 1'b0;
        m_axi.arready = 1'b0; m_axi.rdata = '0; m_axi.rresp = 2'b00; m_axi.rvalid = 1'b0;

        test_reset();
        test_write_zero_wait();
        test_split_write();
        test_read_error();
        test_concurrent();
        test_back_to_back();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule

// File: doc/axi4l_ipif_master.md
# axi4l_ipif_master

AXI4-Lite master that turns the simple single-cycle request/acknowledge register interface (wr_req/wr_ack, rd_req/rd_ack) into AXI4-Lite transactions. It is the initiator-side counterpart of the AXI4-Lite-to-IPIF slave bridge. Typical uses are a local controller, sequencer or debug engine that drives AXI4-Lite peripherals through the interconnect. The write and read paths are independent and may be active at the same time.

## Interface

- C_ADDR_WIDTH, 12: byte-address width on the bus; local addresses are 32-bit-word addresses of C_ADDR_WIDTH-2 bits.
- C_DATA_WIDTH, 32: data width; only 32 or 64 are legal, anything else is an elaboration error.

- aclk  in  1  clock; every signal is synchronous to it.
- aresetn  in  1  synchronous, active-low reset.
- wr_addr  in  C_ADDR_WIDTH-2  write word address.
- wr_req  in  1  single-cycle write request.
- wr_be  in  C_DATA_WIDTH/8  write byte enables.
- wr_data  in  C_DATA_WIDTH  write data.
- wr_ack  out  1  single-cycle write completion.
- wr_err  out  1  BRESP was SLVERR or DECERR; valid with wr_ack.
- wr_busy  out  1  write path not idle.
- rd_addr  in  C_ADDR_WIDTH-2  read word address.
- rd_req  in  1  single-cycle read request.
- rd_data  out  C_DATA_WIDTH  read data; valid with rd_ack.
- rd_ack  out  1  single-cycle read completion.
- rd_err  out  1  RRESP was SLVERR or DECERR; valid with rd_ack.
- rd_busy  out  1  read path not idle.
- m_axi_awaddr  out  32  write address = {zero-extend, wr_addr, 2'b00}.
- m_axi_awprot  out  3  constant 3'b000.
- m_axi_awvalid / m_axi_awready  out / in  1  AW handshake.
- m_axi_wdata  out  C_DATA_WIDTH  write data channel.
- m_axi_wstrb  out  C_DATA_WIDTH/8  write strobes.
- m_axi_wvalid / m_axi_wready  out / in  1  W handshake.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid / m_axi_bready  in / out  1  B handshake.
- m_axi_araddr  out  32  read address = {zero-extend, rd_addr, 2'b00}.
- m_axi_arprot  out  3  constant 3'b000.
- m_axi_arvalid / m_axi_arready  out / in  1  AR handshake.
- m_axi_rdata  in  C_DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid / m_axi_rready  in / out  1  R handshake.

## Operation

**Reset**
- While aresetn=0, every output is 0, including the address, data and strobe registers. Both FSMs go to IDLE.
- Reset asserted mid-transaction abandons it; no ack is generated for it.

**Write FSM: W_IDLE → W_REQ → W_RESP → W_IDLE**
- W_IDLE: on wr_req=1, register wr_addr, wr_data and wr_be into awaddr, wdata and wstrb. Set awvalid=1 and wvalid=1, then go to W_REQ.
- W_REQ: AW and W are tracked independently.
  - awvalid drops on the edge where awvalid&&awready; wvalid drops on the edge where wvalid&&wready.
  - Neither valid drops, and no payload changes, before its own handshake (AXI rule).
  - When both handshakes are done (simultaneous or in either order), go to W_RESP and set bready=1.
- W_RESP: on bvalid&&bready, clear bready, pulse wr_ack=1 for one cycle, set wr_err=bresp[1], and go to W_IDLE.
- wr_busy = (state != W_IDLE). wr_req while wr_busy=1 is ignored: no transaction and no ack.

**Read FSM: R_IDLE → R_ADDR → R_DATA → R_IDLE**
- R_IDLE: on rd_req=1, register araddr, set arvalid=1, and go to R_ADDR.
- R_ADDR: on arvalid&&arready, clear arvalid, set rready=1, and go to R_DATA.
- R_DATA: on rvalid&&rready, clear rready, then:
  - register rd_data=rdata (returned even on error);
  - rd_err=rresp[1];
  - pulse rd_ack for one cycle;
  - go to R_IDLE.
- rd_req while rd_busy=1 is ignored.

**General**
- The write and read FSMs share nothing, so concurrent reads and writes are legal and the bus sees them in any order.
- No combinational path exists from any input to any output. Every AXI output and every local output is a flop.
- No timeout: an AXI master may not abandon an issued transaction. A hung slave leaves busy=1 until reset.
- EXOKAY (2'b01) is treated as success (err=0).

## Timing

- Edge 0 samples wr_req, and awvalid/wvalid go high after edge 0.
- With zero-wait-state ready:
  - AW and W handshakes complete at edge 1;
  - bready is high from edge 1;
  - bvalid is sampled at edge 2;
  - wr_ack is high in the cycle after edge 2.
  - Minimum wr_req→wr_ack latency is 3 cycles.
- Reads: arvalid after edge 0, handshake at edge 1, rready from edge 1, rvalid at edge 2, rd_ack after edge 2. Minimum latency is 3 cycles.
- The FSM is back in IDLE during the ack cycle, so a request presented in the ack cycle is accepted. Maximum issue rate is one transaction per 3 cycles per direction.
- bready and rready are asserted only in W_RESP and R_DATA respectively.
  - bvalid or rvalid arriving early (before bready or rready) is held by the slave and consumed later.
- Each ack is exactly one cycle wide, and rd_data/err hold their values until the next ack.

## Test plan

- Write, zero wait states: wr_addr=0x05, wr_data=0xDEADBEEF, wr_be=0xF, bresp=OKAY.
  - Expect awaddr=0x14, wdata=0xDEADBEEF, wstrb=0xF, wr_ack 3 cycles after wr_req, wr_err=0.
- Split write handshake: awready held low for 4 cycles, wready high immediately.
  - Expect wvalid to drop after 1 cycle while awvalid stays high and stable.
  - Expect bready only after the AW handshake, and wr_ack after bvalid.
- Read with error: rd_addr=0x3FF, arready delayed 2 cycles, rvalid with rdata=0x12345678 and rresp=SLVERR.
  - Expect araddr=0xFFC, rd_data=0x12345678, rd_err=1, rd_ack one cycle wide.
- Concurrent write and read issued in the same cycle with independent random slave delays.
  - Expect both acks with correct data and no cross-corruption.
- Busy and back-to-back:
  - A second wr_req issued while wr_busy=1 → no second AW.
  - A wr_req issued in the wr_ack cycle → a new AW follows on the next cycle.
- Reset mid-operation: aresetn=0 while in W_RESP/R_DATA.
  - Expect all outputs 0 on the next cycle, no ack, and both FSMs idle; then normal operation after release.
